alu_multicycle: RTL



---
 rtl/alu_pkg.sv | 47 ++++
 rtl/alu_multicycle_iter.sv | 83 ++++++++
 rtl/alu_multicycle.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op encodings, FSM states and
// the combinational single-cycle operation function.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;

  // Widest operand the single-cycle function handles; WIDTH must not exceed it.
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  // Single-cycle result on sign-extended operands. Sign extension keeps both
  // the signed and the unsigned ordering of the narrow operands, so one
  // MAX_W-wide compare serves SLT and SLTU; the caller keeps the low bits.
  function automatic logic [MAX_W-1:0] single_op(input logic [3:0]       op,
                                                 input logic [MAX_W-1:0] a,
                                                 input logic [MAX_W-1:0] b);
    logic [MAX_W-1:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_SLT:  r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      OP_SLTU: r = (a < b) ? 64'd1 : 64'd0;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      default: r = 64'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_multicycle_iter.sv
// alu_iter_core: shared shift/add-subtract datapath for unsigned shift-add
// multiply and restoring divide. One adder serves both: it adds the
// multiplicand for MULU and subtracts the divisor for DIVU.
// lo/hi present the register values after the pending step, so the owner
// can capture the final product/quotient on the same edge as the last step.
module alu_iter_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             step,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  logic             div_r;
  logic [WIDTH-1:0] m_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH:0]   x_s;
  logic [WIDTH:0]   y_s;
  logic [WIDTH+1:0] sum_s;
  logic [WIDTH-1:0] hi_nxt_s;
  logic [WIDTH-1:0] lo_nxt_s;

  // One iteration: shift-add for multiply, shift-trial-subtract for divide.
  always_comb begin
    x_s      = div_r ? {hi_r, lo_r[WIDTH-1]} : {1'b0, hi_r};
    y_s      = div_r ? ~{1'b0, m_r} : {1'b0, m_r};
    sum_s    = {1'b0, x_s} + {1'b0, y_s} + {{(WIDTH+1){1'b0}}, div_r};
    hi_nxt_s = hi_r;
    lo_nxt_s = lo_r;
    if (div_r) begin
      // Carry out of the subtract means the shifted remainder >= divisor.
      if (sum_s[WIDTH+1]) begin
        hi_nxt_s = sum_s[WIDTH-1:0];
        lo_nxt_s = {lo_r[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt_s = x_s[WIDTH-1:0];
        lo_nxt_s = {lo_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (lo_r[0]) begin
        hi_nxt_s = sum_s[WIDTH:1];
        lo_nxt_s = {sum_s[0], lo_r[WIDTH-1:1]};
      end else begin
        hi_nxt_s = {1'b0, hi_r[WIDTH-1:1]};
        lo_nxt_s = {hi_r[0], lo_r[WIDTH-1:1]};
      end
    end
  end

  // Operand load on start, one iteration per enabled cycle, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_r <= 1'b0;
      m_r   <= '0;
      hi_r  <= '0;
      lo_r  <= '0;
    end else if (start) begin
      div_r <= op_is_div;
      m_r   <= op_is_div ? b : a;
      lo_r  <= op_is_div ? a : b;
      hi_r  <= '0;
    end else if (step) begin
      hi_r  <= hi_nxt_s;
      lo_r  <= lo_nxt_s;
    end else begin
      hi_r  <= hi_r;
      lo_r  <= lo_r;
    end
  end

  assign lo = lo_nxt_s;
  assign hi = hi_nxt_s;

endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: EX-stage ALU with valid/ready handshake, registered result,
// single-cycle logic/arithmetic ops and WIDTH-iteration MULU/DIVU.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             div_by_zero
);

  localparam int              CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] result_r;
  logic [WIDTH-1:0] result_hi_r;
  logic             zero_r;
  logic             dbz_r;
  logic             dbz_pend_r;
  logic             in_ready_s;
  logic             out_valid_s;
  logic             accept_s;
  logic             is_mul_s;
  logic             is_div_s;
  logic             last_s;
  logic             step_s;
  logic [MAX_W-1:0] a_ext_s;
  logic [MAX_W-1:0] b_ext_s;
  logic [MAX_W-1:0] sc_res_s;
  logic [WIDTH-1:0] core_lo_s;
  logic [WIDTH-1:0] core_hi_s;

  assign accept_s = in_valid & in_ready_s;
  assign is_mul_s = (op == OP_MULU);
  assign is_div_s = (op == OP_DIVU);
  assign last_s   = (cnt_r == CNT_LAST);
  assign step_s   = (state_r == ST_MUL) || (state_r == ST_DIV);

  // Single-cycle result from sign-extended operands.
  always_comb begin
    a_ext_s  = MAX_W'($signed(a));
    b_ext_s  = MAX_W'($signed(b));
    sc_res_s = single_op(op, a_ext_s, b_ext_s);
  end

  generate
    if (WIDTH < MAX_W) begin : g_unused
      logic unused_sc_hi;
      assign unused_sc_hi = ^sc_res_s[MAX_W-1:WIDTH];
    end
  endgenerate

  alu_iter_core #(.WIDTH(WIDTH)) u_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (accept_s & (is_mul_s | is_div_s)),
    .op_is_div (is_div_s),
    .a         (a),
    .b         (b),
    .step      (step_s),
    .lo        (core_lo_s),
    .hi        (core_hi_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (is_mul_s) begin
            state_nxt_s = ST_MUL;
          end else if (is_div_s) begin
            state_nxt_s = ST_DIV;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: handshake flags decoded from the state register.
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    case (state_r)
      ST_IDLE: in_ready_s  = 1'b1;
      ST_DONE: out_valid_s = 1'b1;
      default: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // Iteration counter and result registers; held untouched while in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r       <= '0;
      result_r    <= '0;
      result_hi_r <= '0;
      zero_r      <= 1'b1;
      dbz_r       <= 1'b0;
      dbz_pend_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            cnt_r      <= '0;
            dbz_r      <= 1'b0;
            dbz_pend_r <= is_div_s && (b == '0);
            if (!(is_mul_s || is_div_s)) begin
              result_r    <= sc_res_s[WIDTH-1:0];
              result_hi_r <= '0;
              zero_r      <= (sc_res_s[WIDTH-1:0] == '0);
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (last_s) begin
            result_r    <= core_lo_s;
            result_hi_r <= core_hi_s;
            zero_r      <= (core_lo_s == '0);
            dbz_r       <= dbz_pend_r;
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_s;
  assign out_valid   = out_valid_s;
  assign result      = result_r;
  assign result_hi   = result_hi_r;
  assign zero        = zero_r;
  assign div_by_zero = dbz_r;

endmodule
